// File: rtl/barrel_left_pipe.sv
`default_nettype none
// ============================================================================
// Module   : barrel_left_pipe
// Purpose  : Pipelined barrel LEFT rotator. Stage k rotates its word left by
//            2^k when bit k of the rotate amount is set. sel travels with its
//            word through the pipeline. The whole pipeline advances as one
//            unit: bubbles are not collapsed. Rotating left by sel undoes an
//            upstream right rotation by sel.
// Ports    : clk        - clock, all flops on posedge
//            reset      - asynchronous active-low reset
//            in_valid   - in_data/sel (and dir) valid this cycle
//            in_ready   - block accepts a word this cycle
//            in_data    - word to rotate [data_size-1:0]
//            sel        - left-rotate amount [sel_size-1:0]
//            dir        - (BARREL_DIR_EN only) 0 = left, 1 = right
//            out_valid  - out_data holds a result
//            out_ready  - downstream accepts the result this cycle
//            out_data   - rotated word [data_size-1:0]
// Options  : `define BARREL_DIR_EN adds the dir input. A right rotation is
//            turned into a left rotation by (data_size - sel) mod data_size
//            when the word enters stage 0, so latency is unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module barrel_left_pipe #(
  parameter int data_size = 8,
  parameter int sel_size  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [data_size-1:0] in_data,
  input  logic [sel_size-1:0]  sel,
`ifdef BARREL_DIR_EN
  input  logic                 dir,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [data_size-1:0] out_data
);

  localparam int c_stages = sel_size;

  // data_size must be a power of two, at least 2, and sel_size its log2.
  generate
    if ((data_size < 2) || ((1 << sel_size) != data_size)) begin : g_param_check
      $error("barrel_left_pipe: data_size must be 2**sel_size and >= 2");
    end
  endgenerate

  // Left rotate by a fixed amount in 1..data_size/2.
  function automatic logic [data_size-1:0] rotl(input logic [data_size-1:0] d,
                                                input int unsigned            sh);
    return (d << sh) | (d >> (data_size - sh));
  endfunction

  // Per-stage registers. r_sel holds only the rotate bits not yet consumed:
  // each stage shifts its incoming amount right by one, so bit 0 of a stage's
  // input is always the bit that stage acts on.
  logic                 r_valid [c_stages];
  logic [data_size-1:0] r_data  [c_stages];
  logic [sel_size-1:0]  r_sel   [c_stages];

  // Per-stage inputs: stage 0 from the ports, stage k from stage k-1.
  logic                 w_in_valid [c_stages];
  logic [data_size-1:0] w_in_data  [c_stages];
  logic [sel_size-1:0]  w_in_sel   [c_stages];

  logic                 w_adv;
  logic [sel_size-1:0]  w_sel_eff;

`ifdef BARREL_DIR_EN
  // Right by s == left by (data_size - s) mod data_size; the two's
  // complement of sel in sel_size bits is exactly that, and 0 stays 0.
  assign w_sel_eff = dir ? (~sel + sel_size'(1)) : sel;
`else
  assign w_sel_eff = sel;
`endif

  // The pipeline moves whenever the output slot is empty or being drained.
  assign w_adv    = ~r_valid[c_stages-1] | out_ready;
  assign in_ready = w_adv;

  always_comb begin
    w_in_valid[0] = in_valid;
    w_in_data[0]  = in_data;
    w_in_sel[0]   = w_sel_eff;
    for (int k = 1; k < c_stages; k++) begin
      w_in_valid[k] = r_valid[k-1];
      w_in_data[k]  = r_data[k-1];
      w_in_sel[k]   = r_sel[k-1];
    end
  end

  // Data and sel load regardless of valid; out_data only matters with
  // out_valid, so gating them would buy nothing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < c_stages; k++) begin
        r_valid[k] <= 1'b0;
        r_data[k]  <= '0;
        r_sel[k]   <= '0;
      end
    end else if (w_adv) begin
      for (int k = 0; k < c_stages; k++) begin
        r_valid[k] <= w_in_valid[k];
        r_data[k]  <= w_in_sel[k][0] ? rotl(w_in_data[k], 1 << k) : w_in_data[k];
        r_sel[k]   <= w_in_sel[k] >> 1;
      end
    end
  end

  assign out_valid = r_valid[c_stages-1];
  assign out_data  = r_data[c_stages-1];

endmodule
`default_nettype wire

// File: tb/tb_barrel_left_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_barrel_left_pipe
// Purpose  : Scoreboard bench for barrel_left_pipe (data_size 8, sel_size 3).
//            A driver pushes the model's expected word on every accepted
//            input; a monitor pops and compares on every delivered output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_barrel_left_pipe;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       in_valid  = 1'b0;
  logic       in_ready;
  logic [7:0] in_data   = 8'h00;
  logic [2:0] sel       = 3'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
`ifdef BARREL_DIR_EN
  logic       dir       = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   nvec       = 0;
  int   nerr       = 0;
  int   cyc        = 0;
  int   ready_mode = 0;   // 0: ready high, 1: ready low, 2: random
  bit   check_lat  = 1'b0;

  barrel_left_pipe #(
    .data_size(8),
    .sel_size (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .sel      (sel),
`ifdef BARREL_DIR_EN
    .dir      (dir),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Reference model: rotation as arithmetic on the integer value.
  function automatic logic [7:0] rotl8(input logic [7:0] x, input int s);
    int v;
    v = int'(x);
    return 8'(((v * (1 << s)) + (v / (1 << (8 - s)))) % 256);
  endfunction

  function automatic logic [7:0] rotr8(input logic [7:0] x, input int s);
    return rotl8(x, (8 - s) % 8);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at posedge+2; returns at posedge+2 after the word was taken.
  task automatic send(input logic [7:0] d, input logic [2:0] s, input logic [7:0] exp);
    int waits;
    exp_t e;
    waits    = 0;
    in_valid = 1'b1;
    in_data  = d;
    sel      = s;
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      nvec++;
      nerr++;
      $display("FAIL accept_timeout: in_ready stuck at %b, expected 1", in_ready);
    end else begin
      e.data = exp;
      e.cyc  = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor: every mid-cycle sample outside reset.
  always @(negedge clk) begin
    if (reset) begin
      chk("in_ready", {7'd0, in_ready}, {7'd0, (!out_valid || out_ready)});
      if (out_valid) begin
        if (sb.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_output: got %h, expected no output", out_data);
        end else begin
          chk("out_data", out_data, sb[0].data);
          if (out_ready) begin
            if (check_lat)
              chk("latency", 8'(cyc - sb[0].cyc), 8'd3);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] x;
    int         s;
    int         w;

    // Asynchronous reset from time 1, checked before any clock edge.
    #1 reset = 1'b0;
    #1;
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_out_data",  out_data,          8'h00);
    chk("rst_in_ready",  {7'd0, in_ready},  8'd1);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    idle(1);

    // Basic
    check_lat = 1'b1;
    send(8'h81, 3'd1, 8'h03);
    idle(5);
    send(8'hA5, 3'd3, 8'h2D);
    idle(5);

    // Sweep, back to back
    for (int k = 0; k < 8; k++) send(8'h96, 3'(k), rotl8(8'h96, k));
    idle(5);

    // Backpressure: output slot stalls as the third word enters
    check_lat = 1'b0;
    send(8'h3C, 3'd2, rotl8(8'h3C, 2));
    send(8'hE1, 3'd5, rotl8(8'hE1, 5));
    ready_mode = 1;
    send(8'h5A, 3'd7, rotl8(8'h5A, 7));
    idle(5);
    ready_mode = 0;
    idle(6);

    // Reset mid-flight
    send(8'h11, 3'd4, rotl8(8'h11, 4));
    send(8'h22, 3'd6, rotl8(8'h22, 6));
    idle(1);
    reset = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("mid_rst_out_data",  out_data,          8'h00);
    chk("mid_rst_in_ready",  {7'd0, in_ready},  8'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    send(8'h81, 3'd1, 8'h03);
    idle(1);
    reset = 1'b0;
    sb.delete();
    @(posedge clk);
    #2 reset = 1'b1;
    idle(10);

`ifdef BARREL_DIR_EN
    check_lat = 1'b1;
    dir = 1'b1;
    send(8'hA5, 3'd3, rotr8(8'hA5, 3));
    send(8'hA5, 3'd0, 8'hA5);
    dir = 1'b0;
    send(8'h81, 3'd1, 8'h03);
    send(8'hA5, 3'd3, 8'h2D);
    idle(5);
    check_lat = 1'b0;
`endif

    // Round trip against a right rotation, random backpressure and gaps
    ready_mode = 2;
    for (int k = 0; k < 32; k++) begin
      x = 8'($urandom);
      s = int'($urandom_range(0, 7));
      send(rotr8(x, s), 3'(s), x);
      if ($urandom_range(0, 2) == 0) idle(1);
    end
    ready_mode = 0;

    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    idle(2);
    chk("drain_left", 8'(sb.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
